// File: rtl/reg_wb_ctrl_pkg.sv
// Shared widths, the write-back result record and small helpers for the
// register-file write-back controller.
package reg_wb_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NREGS      = 8;
  localparam int REG_AW     = $clog2(NREGS);
  localparam int LQ_DEPTH   = 2;
  localparam int LQ_CW      = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LQ,
    SRC_LD
  } wb_src_e;

  // One-hot register mask; r0 never maps to a bit so it can never go busy.
  function automatic logic [NREGS-1:0] regMask(input logic [REG_AW-1:0] rd);
    regMask     = '0;
    regMask[rd] = (rd != '0);
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Result, issue and register-file write bundle between the pipeline
// (master) and the write-back controller (slave).
interface reg_wb_if;
  import reg_wb_ctrl_pkg::*;

  logic                  alu_valid;
  logic [REG_AW-1:0]     alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_AW-1:0]     ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  iss_ld;
  logic [REG_AW-1:0]     iss_rd;
  logic [NREGS-1:0]      busy;
  logic                  rf_wr_en;
  logic [REG_AW-1:0]     rf_rd;
  logic [DATA_WIDTH-1:0] rf_din;
  logic                  err_waw;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_ld, iss_rd,
    input  ld_ready, busy, rf_wr_en, rf_rd, rf_din, err_waw
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_ld, iss_rd,
    output ld_ready, busy, rf_wr_en, rf_rd, rf_din, err_waw
  );

endinterface

// File: rtl/reg_wb_ctrl_lfifo.sv
// Small synchronous FIFO holding load results that lost the write port;
// pointers wrap modulo DEPTH (power of two).
module wb_lfifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: emptying the pointers/count discards contents.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: merges ALU and load results into one registered
// register-file write stream, tracks outstanding loads and flags WAW hazards.
module reg_wb_ctrl (
  input  logic     clk,
  input  logic     rst_n,
  reg_wb_if.slave  wb
);
  import reg_wb_ctrl_pkg::*;

  wb_entry_t             aluEntry, ldEntry, lqHead, selEntry;
  wb_src_e               sel;
  logic                  aluHit, ldKeep;
  logic                  lqPush, lqPop, lqFull, lqEmpty;
  logic [LQ_CW-1:0]      lqCount;
  logic [NREGS-1:0]      busy_q, busy_d, busyClr;
  logic                  errWaw_q, errWaw_d;
  logic                  rfWrEn_q;
  logic [REG_AW-1:0]     rfRd_q;
  logic [DATA_WIDTH-1:0] rfDin_q;

  assign wb.ld_ready = rst_n && (lqCount < LQ_CW'(LQ_DEPTH));
  assign wb.busy     = busy_q;
  assign wb.err_waw  = errWaw_q;
  assign wb.rf_wr_en = rfWrEn_q;
  assign wb.rf_rd    = rfRd_q;
  assign wb.rf_din   = rfDin_q;

  wb_lfifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_lfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lqPush),
    .pop_i   (lqPop),
    .din_i   (ldEntry),
    .dout_o  (lqHead),
    .full_o  (lqFull),
    .empty_o (lqEmpty),
    .count_o (lqCount)
  );

  // Write-port arbitration: ALU first, then the oldest queued load, then a
  // fresh load straight through. A fresh load that loses goes to the queue.
  always_comb begin
    aluHit   = wb.alu_valid && (wb.alu_rd != '0);
    ldKeep   = wb.ld_valid && wb.ld_ready && (wb.ld_rd != '0);
    aluEntry = '{rd: wb.alu_rd, data: wb.alu_data};
    ldEntry  = '{rd: wb.ld_rd, data: wb.ld_data};
    sel      = SRC_NONE;
    selEntry = ldEntry;
    lqPop    = 1'b0;
    lqPush   = 1'b0;
    if (aluHit) begin
      sel      = SRC_ALU;
      selEntry = aluEntry;
      lqPush   = ldKeep;
    end else if (!lqEmpty) begin
      sel      = SRC_LQ;
      selEntry = lqHead;
      lqPop    = 1'b1;
      lqPush   = ldKeep;
    end else if (ldKeep) begin
      sel      = SRC_LD;
      selEntry = ldEntry;
    end
    lqPush = lqPush && !lqFull;
  end

  // A new issue to a register overrides a completing load to the same one.
  always_comb begin
    busyClr  = ((sel == SRC_LQ) || (sel == SRC_LD)) ? regMask(selEntry.rd) : '0;
    busy_d   = (busy_q & ~busyClr) | (wb.iss_ld ? regMask(wb.iss_rd) : '0);
    errWaw_d = errWaw_q
             | (aluHit && busy_q[wb.alu_rd])
             | (wb.iss_ld && (wb.iss_rd != '0) && busy_q[wb.iss_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfWrEn_q <= 1'b0;
      rfRd_q   <= '0;
      rfDin_q  <= '0;
      busy_q   <= '0;
      errWaw_q <= 1'b0;
    end else begin
      rfWrEn_q <= (sel != SRC_NONE);
      if (sel != SRC_NONE) begin
        rfRd_q  <= selEntry.rd;
        rfDin_q <= selEntry.data;
      end
      busy_q   <= busy_d;
      errWaw_q <= errWaw_d;
    end
  end

endmodule
